bicubic_window_feeder: RTL and testbench

- Producer side of the bicubic core's window interface.
- Accepts a raster pixel stream over a valid/ready handshake and keeps three line buffers.
- Each cycle it drives four vertically aligned pixels (row0 = current line, row3 = three lines above) plus a shift strobe, with edge replication.
- It also emits window-valid and coordinate tags so downstream can align weights and capture outputs.

---
 rtl/bicubic_window_feeder_pkg.sv | 22 ++
 rtl/bicubic_window_feeder_line_buffer.sv | 26 ++
 rtl/bicubic_window_feeder.sv | 144 ++++++++++++++
 tb/tb_bicubic_window_feeder.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bicubic_window_feeder_pkg.sv
// Shared definitions for the bicubic window feeder: FSM state encoding and
// the padding/tap constants that shape a line of column shifts.
package bicubic_window_feeder_pkg;

  // Feeder sequencing: normal accept, left replication, two right replications.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    LPAD  = 2'd1,
    RPAD1 = 2'd2,
    RPAD2 = 2'd3
  } feeder_state_e;

  localparam int LPAD_SHIFTS = 1;  // extra copies of x0 at the start of a line
  localparam int RPAD_SHIFTS = 2;  // extra copies of x(W-1) at the end of a line
  localparam int WINDOW_TAPS = 4;  // horizontal taps in a bicubic window

  // Column shifts the core sees for one input line of width w.
  function automatic int shifts_per_line(input int w);
    return w + LPAD_SHIFTS + RPAD_SHIFTS;
  endfunction

endpackage

// File: rtl/bicubic_window_feeder_line_buffer.sv
// One line of pixel history: single-port RAM with asynchronous read, so a
// read and a write at the same address in one cycle return the old data.
module line_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 64,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  // NOTE: pixel storage has no reset; stale contents are masked by the top clamp.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  // Write the new column value; the read above still sees the previous one.
  // NOTE: sequential state is always updated with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/bicubic_window_feeder.sv
// Producer side of the bicubic core's window interface. Streams raster
// pixels through three line buffers and emits one vertical 4-pixel column
// per shift, replicating at the left, right and top image edges.
module bicubic_window_feeder
  import bicubic_window_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64,
  parameter int XW         = $clog2(IMG_WIDTH + 3),
  parameter int YW         = $clog2(IMG_HEIGHT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_pixel,
  output logic [DATA_WIDTH-1:0] row0_in,
  output logic [DATA_WIDTH-1:0] row1_in,
  output logic [DATA_WIDTH-1:0] row2_in,
  output logic [DATA_WIDTH-1:0] row3_in,
  output logic                  shift_window,
  output logic                  win_valid,
  output logic [XW-1:0]         win_x,
  output logic [YW-1:0]         win_y,
  output logic                  eof
);

  localparam int            CW         = $clog2(IMG_WIDTH);
  localparam logic [CW-1:0] COL_LAST   = CW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] LINE_LAST  = YW'(IMG_HEIGHT - 1);
  localparam logic [XW-1:0] FIRST_WIN  = XW'(WINDOW_TAPS - 1);
  localparam logic [XW-1:0] SHIFT_LAST = XW'(shifts_per_line(IMG_WIDTH) - 1);

  feeder_state_e         state;
  logic [CW-1:0]         col_q;
  logic [YW-1:0]         line_q;
  logic [XW-1:0]         shift_idx;

  logic                  accept;
  logic                  do_shift;
  logic [DATA_WIDTH-1:0] lb_rd0, lb_rd1, lb_rd2;
  logic [DATA_WIDTH-1:0] nxt_row1, nxt_row2, nxt_row3;

  assign accept   = s_valid && s_ready;
  // Pad states always shift; RUN shifts only on an accepted pixel.
  assign do_shift = accept || (state != RUN);

  // Three-deep vertical history: each accept pushes the column down one line.
  line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH), .AW(CW)) u_lb0 (
    .clk(clk), .we(accept), .addr(col_q), .wdata(s_pixel), .rdata(lb_rd0)
  );
  line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH), .AW(CW)) u_lb1 (
    .clk(clk), .we(accept), .addr(col_q), .wdata(lb_rd0), .rdata(lb_rd1)
  );
  line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH), .AW(CW)) u_lb2 (
    .clk(clk), .we(accept), .addr(col_q), .wdata(lb_rd1), .rdata(lb_rd2)
  );

  // Top-edge clamp: rows above line 0 fall back to the oldest valid line.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    nxt_row1 = s_pixel;
    nxt_row2 = s_pixel;
    nxt_row3 = s_pixel;
    if (int'(line_q) >= 1) begin
      nxt_row1 = lb_rd0;
      nxt_row2 = lb_rd0;
      nxt_row3 = lb_rd0;
    end
    if (int'(line_q) >= 2) begin
      nxt_row2 = lb_rd1;
      nxt_row3 = lb_rd1;
    end
    if (int'(line_q) >= 3) begin
      nxt_row3 = lb_rd2;
    end
  end

  // Sequencer: handshake, padding shifts, counters and registered window tags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= RUN;
      s_ready      <= 1'b0;
      col_q        <= '0;
      line_q       <= '0;
      shift_idx    <= '0;
      row0_in      <= '0;
      row1_in      <= '0;
      row2_in      <= '0;
      row3_in      <= '0;
      shift_window <= 1'b0;
      win_valid    <= 1'b0;
      win_x        <= '0;
      win_y        <= '0;
      eof          <= 1'b0;
    end else begin
      shift_window <= do_shift;
      win_valid    <= do_shift && (shift_idx >= FIRST_WIN);
      eof          <= 1'b0;

      if (do_shift) begin
        win_x     <= shift_idx - FIRST_WIN;
        win_y     <= line_q;
        shift_idx <= (shift_idx == SHIFT_LAST) ? '0 : shift_idx + XW'(1);
      end

      case (state)
        RUN: begin
          s_ready <= 1'b1;
          if (accept) begin
            row0_in <= s_pixel;
            row1_in <= nxt_row1;
            row2_in <= nxt_row2;
            row3_in <= nxt_row3;
            col_q   <= (col_q == COL_LAST) ? '0 : col_q + CW'(1);
            if (col_q == '0) begin
              state   <= LPAD;
              s_ready <= 1'b0;
            end else if (col_q == COL_LAST) begin
              state   <= RPAD1;
              s_ready <= 1'b0;
            end
          end
        end
        LPAD: begin
          state   <= RUN;
          s_ready <= 1'b1;
        end
        RPAD1: begin
          state <= RPAD2;
        end
        RPAD2: begin
          state   <= RUN;
          s_ready <= 1'b1;
          line_q  <= (line_q == LINE_LAST) ? '0 : line_q + YW'(1);
          eof     <= (line_q == LINE_LAST);
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_bicubic_window_feeder.sv
// Self-checking bench for bicubic_window_feeder with a 4x4 image.
module tb_bicubic_window_feeder;

  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int XW = $clog2(W + 3);
  localparam int YW = $clog2(H);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_pixel = '0;
  logic [DW-1:0] row0_in, row1_in, row2_in, row3_in;
  logic          shift_window, win_valid, eof;
  logic [XW-1:0] win_x;
  logic [YW-1:0] win_y;

  int checks   = 0;
  int failures = 0;
  int n_shift  = 0;
  int n_win    = 0;
  int n_acc    = 0;

  bicubic_window_feeder #(
    .DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .XW(XW), .YW(YW)
  ) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_pixel(s_pixel),
    .row0_in(row0_in), .row1_in(row1_in), .row2_in(row2_in), .row3_in(row3_in),
    .shift_window(shift_window), .win_valid(win_valid), .win_x(win_x),
    .win_y(win_y), .eof(eof)
  );

  always #5 clk = ~clk;

  // Traffic counters, sampled mid-cycle when everything is stable.
  always @(negedge clk) begin
    if (rst) begin
      if (shift_window)       n_shift <= n_shift + 1;
      if (win_valid)          n_win   <= n_win + 1;
      if (s_valid && s_ready) n_acc   <= n_acc + 1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pix(input int base, input int y, input int x);
    int yy;
    yy = (y < 0) ? 0 : y;
    return DW'(base + 16 * yy + x);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one pixel and return #1 after the edge that accepted it.
  task automatic send(input logic [DW-1:0] p);
    bit was_ready;
    bit done;
    done    = 1'b0;
    s_valid = 1'b1;
    s_pixel = p;
    for (int n = 0; n < 16 && !done; n++) begin
      was_ready = s_ready;
      step();
      if (was_ready) done = 1'b1;
    end
    if (!done) check("send_timeout", 32'd0, 32'd1);
  endtask

  // One shift of line y at column x, shift index si.
  task automatic check_shift(input string tag, input int base, input int y, input int x,
                             input int si, input bit exp_eof);
    check({tag, "_shift"}, shift_window, 1);
    check({tag, "_row0"}, row0_in, pix(base, y, x));
    check({tag, "_row1"}, row1_in, pix(base, y - 1, x));
    check({tag, "_row2"}, row2_in, pix(base, y - 2, x));
    check({tag, "_row3"}, row3_in, pix(base, y - 3, x));
    check({tag, "_wvalid"}, win_valid, (si >= 3) ? 1 : 0);
    if (si >= 3) check({tag, "_wx"}, win_x, si - 3);
    check({tag, "_wy"}, win_y, y);
    check({tag, "_eof"}, eof, exp_eof ? 1 : 0);
  endtask

  // Feed a whole line with valid held high (optionally a 2-cycle gap before x=2).
  task automatic run_line(input int base, input int y, input bit gap);
    int si;
    si = 0;
    for (int x = 0; x < W; x++) begin
      if (gap && x == 2) begin
        s_valid = 1'b0;
        for (int g = 0; g < 2; g++) begin
          step();
          check("gap_shift", shift_window, 0);
          check("gap_row0", row0_in, pix(base, y, 1));
          check("gap_row1", row1_in, pix(base, y - 1, 1));
        end
      end
      send(pix(base, y, x));
      check_shift($sformatf("y%0d_x%0d", y, x), base, y, x, si, 1'b0);
      si++;
      if (x == 0) begin
        check("lpad_ready", s_ready, 0);
        s_pixel = 8'hEE;
        step();
        check_shift($sformatf("y%0d_lpad", y), base, y, 0, si, 1'b0);
        si++;
      end
      if (x == W - 1) begin
        s_pixel = 8'hEE;
        check("rpad_ready", s_ready, 0);
        step();
        check_shift($sformatf("y%0d_rpad1", y), base, y, x, si, 1'b0);
        si++;
        step();
        check_shift($sformatf("y%0d_rpad2", y), base, y, x, si, y == H - 1);
        si++;
      end
    end
  endtask

  typedef struct {
    logic          v;
    logic [DW-1:0] px;
    logic          rdy;
    logic          sh;
    logic [DW-1:0] r0, r1, r2, r3;
    logic          wv;
    logic [XW-1:0] wx;
    logic [YW-1:0] wy;
    logic          eof;
  } vec_t;

  vec_t tbl[15];
  int   s_shift, s_win, s_acc;

  initial begin
    // inputs before the edge                 expected after the edge
    //          v  px   rdy sh r0  r1 r2 r3 wv wx wy eof
    tbl[0]  = '{1, 0,    1, 0, 0,  0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 0,    0, 1, 0,  0, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, 1,    1, 1, 0,  0, 0, 0, 0, 0, 0, 0};
    tbl[3]  = '{1, 1,    1, 1, 1,  1, 1, 1, 0, 0, 0, 0};
    tbl[4]  = '{1, 2,    1, 1, 2,  2, 2, 2, 1, 0, 0, 0};
    tbl[5]  = '{1, 3,    0, 1, 3,  3, 3, 3, 1, 1, 0, 0};
    tbl[6]  = '{1, 8'hEE,0, 1, 3,  3, 3, 3, 1, 2, 0, 0};
    tbl[7]  = '{1, 8'hEE,1, 1, 3,  3, 3, 3, 1, 3, 0, 0};
    tbl[8]  = '{1, 16,   0, 1, 16, 0, 0, 0, 0, 0, 1, 0};
    tbl[9]  = '{1, 17,   1, 1, 16, 0, 0, 0, 0, 0, 1, 0};
    tbl[10] = '{1, 17,   1, 1, 17, 1, 1, 1, 0, 0, 1, 0};
    tbl[11] = '{1, 18,   1, 1, 18, 2, 2, 2, 1, 0, 1, 0};
    tbl[12] = '{1, 19,   0, 1, 19, 3, 3, 3, 1, 1, 1, 0};
    tbl[13] = '{1, 8'hEE,0, 1, 19, 3, 3, 3, 1, 2, 1, 0};
    tbl[14] = '{1, 8'hEE,1, 1, 19, 3, 3, 3, 1, 3, 1, 0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", s_ready, 0);
    check("rst_shift", shift_window, 0);
    check("rst_row0", row0_in, 0);
    check("rst_row3", row3_in, 0);
    check("rst_wvalid", win_valid, 0);
    check("rst_eof", eof, 0);

    // Frame 0, lines 0 and 1 from the vector table
    rst     = 1'b1;
    s_valid = 1'b1;
    s_pixel = '0;
    for (int i = 0; i < 15; i++) begin
      s_valid = tbl[i].v;
      s_pixel = tbl[i].px;
      step();
      check($sformatf("t%0d_ready", i), s_ready, tbl[i].rdy);
      check($sformatf("t%0d_shift", i), shift_window, tbl[i].sh);
      check($sformatf("t%0d_row0", i), row0_in, tbl[i].r0);
      check($sformatf("t%0d_row1", i), row1_in, tbl[i].r1);
      check($sformatf("t%0d_row2", i), row2_in, tbl[i].r2);
      check($sformatf("t%0d_row3", i), row3_in, tbl[i].r3);
      check($sformatf("t%0d_wvalid", i), win_valid, tbl[i].wv);
      if (tbl[i].wv) check($sformatf("t%0d_wx", i), win_x, tbl[i].wx);
      check($sformatf("t%0d_wy", i), win_y, tbl[i].wy);
      check($sformatf("t%0d_eof", i), eof, tbl[i].eof);
    end

    // Frame 0, lines 2 (with a valid gap) and 3 (eof); y=3,x=2 gives 50,34,18,2
    run_line(0, 2, 1'b1);
    run_line(0, 3, 1'b0);

    // Frame 1 with a different base: y=0 must not show frame-0 data
    for (int y = 0; y < H; y++) run_line(100, y, 1'b0);

    // Frame 2: reset asserted while in RPAD1 of line 2
    run_line(200, 0, 1'b0);
    run_line(200, 1, 1'b0);
    for (int x = 0; x < W; x++) begin
      send(pix(200, 2, x));
      if (x == 0) step();
    end
    check("pre_rst_shift", shift_window, 1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_ready", s_ready, 0);
    check("arst_shift", shift_window, 0);
    check("arst_row0", row0_in, 0);
    check("arst_row1", row1_in, 0);
    check("arst_wvalid", win_valid, 0);
    check("arst_wy", win_y, 0);
    s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("post_rst_noshift", shift_window, 0);
    end
    check("post_rst_ready", s_ready, 1);

    // One continuous line after reset: W+3 shifts, W accepts, W windows
    s_shift = n_shift;
    s_win   = n_win;
    s_acc   = n_acc;
    run_line(60, 0, 1'b0);
    s_valid = 1'b0;
    repeat (2) step();
    check("line_shift_count", n_shift - s_shift, W + 3);
    check("line_win_count", n_win - s_win, W);
    check("line_accept_count", n_acc - s_acc, W);
    check("idle_shift", shift_window, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
